// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a first-word-fall-through byte FIFO; rx_valid rises 1 cycle after the stop sample.
// No backpressure on the serial line: a good byte that arrives while the FIFO is full (and not being popped) is dropped and sets overrun.
module uart_rx_fifo #(
  parameter int CYCLES_PER_BIT = 87,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CYCLES_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT  = CW'(CYCLES_PER_BIT);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic          rx_prev_q, rx_prev_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_err_q, parity_err_d;
  logic          par_set;
`endif

  logic fall, tick, push, frame_set, pop, full, wr_en, overrun_set;

  assign fall = rx_prev_q & ~rx_s_q;
  assign tick = (cnt_q == CW'(1));

  // Receive FSM: each bit period is timed by cnt_q counting down to 1.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    if (state_q != IDLE && !tick) begin
      cnt_d = cnt_q - CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = HALF_BIT;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = FULL_BIT;
            bit_idx_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          data_d = {rx_s_q, data_q[7:1]};
          cnt_d  = FULL_BIT;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_d = (^data_q) ^ rx_s_q;
          par_set   = (^data_q) ^ rx_s_q;
          cnt_d     = FULL_BIT;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            push = ~par_bad_q;
`else
            push = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO only succeeds alongside a pop.
  always_comb begin
    pop         = rd_en & rx_valid;
    full        = (count_q == DEPTH_CNT);
    wr_en       = push & (~full | pop);
    overrun_set = push & full & ~pop;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = data_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    frame_err_d = (frame_err_q & ~clr_err) | frame_set;
    overrun_d   = (overrun_q & ~clr_err) | overrun_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (parity_err_q & ~clr_err) | par_set;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_valid  = (count_q != '0);
  assign rx_full   = (count_q == DEPTH_CNT);
  assign rd_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: randomized serial frames checked against a queue-based model of the receive FIFO and sticky flags.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, rx_full, frame_err, overrun, parity_err;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: byte queue plus the three sticky flags.
  logic [7:0] exp_q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;
  logic       exp_pe = 1'b0;

  int   cyc = 0;
  int   rise_cyc = 0;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
    if (!par_ok) exp_pe = 1'b1;
    if (!stop_b) exp_fe = 1'b1;
    else if (par_ok) begin
      if (exp_q.size() == DEPTH) exp_ov = 1'b1;
      else exp_q.push_back(d);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk);
    rx = b;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic flip, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip);
`endif
    drive_bit(stop_b);
    if (gap > 0) begin
      @(posedge clk);
      rx = 1'b1;
      repeat (gap - 1) @(posedge clk);
    end
    model_frame(d, stop_b, PAR_EN ? ~flip : 1'b1);
  endtask

  task automatic pop_byte();
    @(posedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    clr_err = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    exp_pe = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    exp_pe = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else passed++;
    checks++; if (rx_full !== 1'b0) $display("FAIL reset_rx_full: got %b want 0", rx_full); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", parity_err); else passed++;
  endtask

  task automatic test_single();
    int start_cyc;
    int lat;
    @(negedge clk);
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b0, 4);
    @(negedge clk);
    lat = rise_cyc - start_cyc;
    checks++; if (rx_valid !== 1'b1) $display("FAIL single_rx_valid: got %b want 1", rx_valid); else passed++;
    checks++; if (lat < 77 || lat > 81) $display("FAIL single_latency: got %0d want 77..81 cycles", lat); else passed++;
    checks++; if (rd_data !== 8'hA5) $display("FAIL single_rd_data: got %h want a5", rd_data); else passed++;
    pop_byte();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL single_pop_valid: got %b want 0", rx_valid); else passed++;
    checks++; if (rd_data !== 8'h00) $display("FAIL single_empty_data: got %h want 00", rd_data); else passed++;
    // rd_en while empty must be ignored
    pop_byte();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL single_empty_pop: got %b want 0", rx_valid); else passed++;
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    @(posedge clk);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (CPB * 12) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL glitch_rx_valid: got %b want 0", rx_valid); else passed++;
    checks++; if ({frame_err, overrun, parity_err} !== 3'b000)
      $display("FAIL glitch_flags: got %b want 000", {frame_err, overrun, parity_err}); else passed++;
    d = 8'($urandom);
    send_frame(d, 1'b1, 1'b0, 4);
    @(negedge clk);
    checks++; if (rd_data !== exp_q[0]) $display("FAIL glitch_after_byte: got %h want %h", rd_data, exp_q[0]); else passed++;
    pop_byte();
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0, 4);
    @(negedge clk);
    checks++; if (frame_err !== exp_fe) $display("FAIL ferr_set: got %b want %b", frame_err, exp_fe); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL ferr_rx_valid: got %b want 0", rx_valid); else passed++;
    pulse_clr();
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) $display("FAIL ferr_clear: got %b want 0", frame_err); else passed++;
  endtask

  task automatic test_overrun();
    logic [7:0] want;
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1, 1'b0, 3);
    @(negedge clk);
    checks++; if (rx_full !== 1'b1) $display("FAIL ovr_full: got %b want 1", rx_full); else passed++;
    checks++; if (overrun !== exp_ov) $display("FAIL ovr_flag: got %b want %b", overrun, exp_ov); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      want = exp_q[0];
      checks++; if (rd_data !== want) $display("FAIL ovr_pop%0d: got %h want %h", i, rd_data, want); else passed++;
      pop_byte();
      @(negedge clk);
      checks++; if (rx_full !== 1'b0) $display("FAIL ovr_full_after_pop%0d: got %b want 0", i, rx_full); else passed++;
    end
    checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", rx_valid); else passed++;
    pulse_clr();
    @(negedge clk);
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_reset_mid();
    send_frame(8'($urandom), 1'b1, 1'b0, 3);
    send_frame(8'($urandom), 1'b0, 1'b0, 3);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    @(posedge clk);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    exp_pe = 1'b0;
    repeat (CPB * 12) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL rstmid_empty: got %b want 0", rx_valid); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr: got %b want 0", frame_err); else passed++;
    send_frame(8'h3C, 1'b1, 1'b0, 4);
    @(negedge clk);
    checks++; if (rd_data !== 8'h3C) $display("FAIL rstmid_byte: got %h want 3c", rd_data); else passed++;
    pop_byte();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL rstmid_only_one: got %b want 0", rx_valid); else passed++;
    checks++; if ({frame_err, overrun, parity_err} !== 3'b000)
      $display("FAIL rstmid_flags: got %b want 000", {frame_err, overrun, parity_err}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0, (i == DEPTH - 1) ? 4 : 0);
    @(negedge clk);
    checks++; if (rx_full !== 1'b1) $display("FAIL b2b_full: got %b want 1", rx_full); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      want = exp_q[0];
      checks++; if (rd_data !== want) $display("FAIL b2b_pop%0d: got %h want %h", i, rd_data, want); else passed++;
      pop_byte();
      @(negedge clk);
    end
    checks++; if (rx_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", rx_valid); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] want;
    logic       stop_b, flip;
    for (int n = 0; n < 30; n++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 5) != 0);
      flip   = PAR_EN && ($urandom_range(0, 4) == 0);
      send_frame(d, stop_b, flip, $urandom_range(2, 6));
      @(negedge clk);
      want = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
      checks++; if (rx_valid !== (exp_q.size() != 0)) $display("FAIL rnd%0d_valid: got %b want %b", n, rx_valid, exp_q.size() != 0); else passed++;
      checks++; if (rx_full !== (exp_q.size() == DEPTH)) $display("FAIL rnd%0d_full: got %b want %b", n, rx_full, exp_q.size() == DEPTH); else passed++;
      checks++; if (rd_data !== want) $display("FAIL rnd%0d_data: got %h want %h", n, rd_data, want); else passed++;
      checks++; if ({frame_err, overrun, parity_err} !== {exp_fe, exp_ov, exp_pe})
        $display("FAIL rnd%0d_flags: got %b want %b", n, {frame_err, overrun, parity_err}, {exp_fe, exp_ov, exp_pe}); else passed++;
      if ($urandom_range(0, 2) == 0) pop_byte();
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    do_reset();
    send_frame(8'h07, 1'b1, 1'b0, 4);
    @(negedge clk);
    checks++; if (rd_data !== 8'h07) $display("FAIL par_good_data: got %h want 07", rd_data); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL par_good_flag: got %b want 0", parity_err); else passed++;
    send_frame(8'h07, 1'b1, 1'b1, 4);
    @(negedge clk);
    checks++; if (parity_err !== exp_pe) $display("FAIL par_bad_flag: got %b want %b", parity_err, exp_pe); else passed++;
    checks++; if (rx_full !== 1'b0 || rd_data !== 8'h07)
      $display("FAIL par_bad_fifo: got full=%b data=%h want full=0 data=07", rx_full, rd_data); else passed++;
    pop_byte();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL par_bad_dropped: got %b want 0", rx_valid); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
